// File: rtl/controle_pkg.sv
// Shared types and default constants for the lamp controller.
package controle_pkg;

  typedef enum logic [1:0] {
    AUTO_OFF = 2'b00,
    AUTO_ON  = 2'b01,
    MAN_OFF  = 2'b10,
    MAN_ON   = 2'b11
  } estado_t;

  localparam int HOLD_T_DEF = 30000;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/controle_lampada_sincronizador.sv
// Two-flop synchronizer for asynchronous level inputs, synchronous active-high reset.
module sincronizador #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/controle_lampada.sv
// Lamp controller: auto mode (presence + dark with hold timer) and manual mode
// toggled by push-button pulses A (mode) and B (lamp).
module controle_lampada
  import controle_pkg::*;
#(
  parameter int HOLD_T = HOLD_T_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             sensor_presenca,
  input  logic             escuro,
  output logic             lampada,
  output logic             modo_manual,
  output estado_t          estado,
  output logic [CNT_W-1:0] contador
);

  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(HOLD_T - 1);

  logic pres_s;
  logic esc_s;

  sincronizador #(.W(1)) u_sinc_pres (
    .clk (clk),
    .rst (rst),
    .d   (sensor_presenca),
    .q   (pres_s)
  );

  sincronizador #(.W(1)) u_sinc_esc (
    .clk (clk),
    .rst (rst),
    .d   (escuro),
    .q   (esc_s)
  );

  // A and B are single-cycle event strobes with no ready: every cycle they are
  // high counts as one event, and A wins over B, sensors and timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= AUTO_OFF;
      contador <= '0;
    end else if (A) begin
      case (estado)
        AUTO_OFF: estado <= MAN_OFF;
        AUTO_ON:  estado <= MAN_ON;
        default: begin
          estado   <= AUTO_OFF;
          contador <= '0;
        end
      endcase
    end else begin
      case (estado)
        AUTO_OFF: begin
          if (pres_s && esc_s) begin
            estado   <= AUTO_ON;
            contador <= '0;
          end
        end
        AUTO_ON: begin
          if (pres_s) begin
            contador <= '0;
          end else if (contador >= LIMITE) begin
            estado   <= AUTO_OFF;
            contador <= '0;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        MAN_OFF: if (B) estado <= MAN_ON;
        MAN_ON:  if (B) estado <= MAN_OFF;
        default: begin
          estado   <= AUTO_OFF;
          contador <= '0;
        end
      endcase
    end
  end

  assign lampada     = (estado == AUTO_ON) || (estado == MAN_ON);
  assign modo_manual = (estado == MAN_OFF) || (estado == MAN_ON);

endmodule

// File: tb/tb_controle_lampada.sv
// Directed bench for controle_lampada with HOLD_T=8.
module tb_controle_lampada;
  import controle_pkg::*;

  localparam int HOLD_T = 8;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             A;
  logic             B;
  logic             sensor_presenca;
  logic             escuro;
  logic             lampada;
  logic             modo_manual;
  estado_t          estado;
  logic [CNT_W-1:0] contador;

  int total = 0;
  int fails = 0;

  controle_lampada #(.HOLD_T(HOLD_T), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .A               (A),
    .B               (B),
    .sensor_presenca (sensor_presenca),
    .escuro          (escuro),
    .lampada         (lampada),
    .modo_manual     (modo_manual),
    .estado          (estado),
    .contador        (contador)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic lamp, input logic man);
    check({tag, "_lampada"}, 16'(lampada), 16'(lamp));
    check({tag, "_modo"}, 16'(modo_manual), 16'(man));
  endtask

  initial begin
    rst = 1'b1; A = 1'b0; B = 1'b0; sensor_presenca = 1'b0; escuro = 1'b0;
    ticks(2);
    check_out("reset", 1'b0, 1'b0);
    check("reset_estado", 16'(estado), 16'(AUTO_OFF));
    check("reset_cnt", contador, 16'd0);
    rst = 1'b0;

    // Dark, one-cycle presence pulse: on after 3 edges, off 8 edges after pres_s falls
    escuro = 1'b1;
    ticks(3);
    sensor_presenca = 1'b1;
    tick();
    sensor_presenca = 1'b0;
    tick();
    check_out("pulse_e2", 1'b0, 1'b0);
    tick();
    check_out("pulse_e3", 1'b1, 1'b0);
    check("pulse_cnt0", contador, 16'd0);
    ticks(7);
    check_out("pulse_hold7", 1'b1, 1'b0);
    check("pulse_cnt7", contador, 16'd7);
    tick();
    check_out("pulse_off", 1'b0, 1'b0);

    // Bright with presence: stays off; then dark: on after 3 edges
    escuro = 1'b0;
    ticks(3);
    sensor_presenca = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bright_off", 16'(lampada), 16'd0);
    end
    escuro = 1'b1;
    ticks(2);
    check_out("dark_e2", 1'b0, 1'b0);
    tick();
    check_out("dark_e3", 1'b1, 1'b0);
    sensor_presenca = 1'b0;
    ticks(12);
    check_out("dark_timeout", 1'b0, 1'b0);

    // Retrigger: pres_s seen while counter=6 clears it
    sensor_presenca = 1'b1;
    tick();
    sensor_presenca = 1'b0;
    ticks(2);
    check_out("retrig_on", 1'b1, 1'b0);
    ticks(4);
    check("retrig_cnt4", contador, 16'd4);
    sensor_presenca = 1'b1;
    tick();
    sensor_presenca = 1'b0;
    tick();
    check("retrig_cnt6", contador, 16'd6);
    tick();
    check("retrig_clear", contador, 16'd0);
    check_out("retrig_lamp", 1'b1, 1'b0);
    ticks(7);
    check_out("retrig_hold", 1'b1, 1'b0);
    tick();
    check_out("retrig_off", 1'b0, 1'b0);

    // A in AUTO_ON -> MAN_ON, then B toggles, sensors ignored
    sensor_presenca = 1'b1;
    tick();
    sensor_presenca = 1'b0;
    ticks(2);
    check_out("man_pre", 1'b1, 1'b0);
    A = 1'b1;
    tick();
    A = 1'b0;
    check("man_estado", 16'(estado), 16'(MAN_ON));
    check_out("man_on", 1'b1, 1'b1);
    check("man_cnt_held", contador, 16'd0);
    B = 1'b1;
    tick();
    B = 1'b0;
    check_out("man_b1", 1'b0, 1'b1);
    sensor_presenca = 1'b1;
    ticks(5);
    check_out("man_sensor_ign", 1'b0, 1'b1);
    B = 1'b1;
    sensor_presenca = 1'b0;
    tick();
    B = 1'b0;
    check_out("man_b2", 1'b1, 1'b1);
    ticks(3);
    check_out("man_stable", 1'b1, 1'b1);

    // A and B together in MAN_ON: A wins, no toggle
    A = 1'b1; B = 1'b1;
    tick();
    A = 1'b0; B = 1'b0;
    check("ab_estado", 16'(estado), 16'(AUTO_OFF));
    check_out("ab_out", 1'b0, 1'b0);
    check("ab_cnt", contador, 16'd0);
    tick();
    check_out("ab_next", 1'b0, 1'b0);

    // B ignored in auto states
    B = 1'b1;
    tick();
    B = 1'b0;
    check("b_ignored", 16'(estado), 16'(AUTO_OFF));

    // A held two cycles: two events
    A = 1'b1;
    tick();
    check("a_held1", 16'(estado), 16'(MAN_OFF));
    tick();
    A = 1'b0;
    check("a_held2", 16'(estado), 16'(AUTO_OFF));

    // Reset in MAN_ON
    A = 1'b1;
    tick();
    A = 1'b0;
    B = 1'b1;
    tick();
    B = 1'b0;
    check("rst_man_pre", 16'(estado), 16'(MAN_ON));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("rst_man", 1'b0, 1'b0);
    check("rst_man_cnt", contador, 16'd0);

    // Reset in AUTO_ON at counter 5 overriding A and presence
    sensor_presenca = 1'b1;
    tick();
    sensor_presenca = 1'b0;
    ticks(2);
    ticks(5);
    check("rst_auto_cnt5", contador, 16'd5);
    check_out("rst_auto_pre", 1'b1, 1'b0);
    rst = 1'b1; A = 1'b1; sensor_presenca = 1'b1;
    tick();
    rst = 1'b0; A = 1'b0; sensor_presenca = 1'b0;
    check_out("rst_auto", 1'b0, 1'b0);
    check("rst_auto_cnt", contador, 16'd0);
    tick();
    check("rst_after", 16'(estado), 16'(AUTO_OFF));

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/controle_lampada.md
CONTROLE_LAMPADA -- requirements
Module: controle_lampada

Interface
REQ-001 SHALL have parameter HOLD_T, default 30000: auto-mode on-time in clk cycles after last presence; legal range 1..65535.
REQ-002 SHALL have parameter CNT_W, default 16: hold counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port A  input  1  one-cycle pulse from the push-button stage; long press means toggle mode.
REQ-006 SHALL have port B  input  1  one-cycle pulse from the push-button stage; short press means toggle lamp in manual mode.
REQ-007 SHALL have port sensor_presenca  input  1  asynchronous PIR presence level.
REQ-008 SHALL have port escuro  input  1  asynchronous ambient-dark level; 1 means dark.
REQ-009 SHALL have port lampada  output  1  lamp drive; 1 means on.
REQ-010 SHALL have port modo_manual  output  1  mode indicator; 1 means manual.

Function
REQ-011 SHALL pass sensor_presenca and escuro each through a 2-flop synchronizer; only synchronized versions (pres_s, esc_s) used internally.
REQ-012 SHALL implement FSM with states AUTO_OFF, AUTO_ON, MAN_OFF, MAN_ON.
REQ-013 SHALL decode outputs from state register only: lampada=1 in AUTO_ON/MAN_ON, modo_manual=1 in MAN_OFF/MAN_ON.
REQ-014 SHALL, in AUTO_OFF: go AUTO_ON when pres_s and esc_s both 1, clearing counter to 0.
REQ-015 SHALL, in AUTO_ON: clear counter to 0 on pres_s=1 (retrigger, escuro ignored); else increment counter; go AUTO_OFF when counter==HOLD_T-1 and pres_s=0.
REQ-016 SHALL, on A in AUTO_OFF go MAN_OFF; on A in AUTO_ON go MAN_ON (lamp state preserved).
REQ-017 SHALL, on A in MAN_OFF or MAN_ON go AUTO_OFF with counter cleared; lamp then re-evaluated by REQ-014 next cycle.
REQ-018 SHALL toggle MAN_OFF<->MAN_ON on B; sensors have no effect in manual states.
REQ-019 SHALL ignore B in auto states.
REQ-020 SHALL give A priority when A and B are both 1 in the same cycle; B discarded.
REQ-021 SHALL give A priority over sensor transitions and timeout in the same cycle.
REQ-022 SHALL hold counter in manual states; counter never wraps (saturates at HOLD_T-1).
REQ-023 SHALL have latency: sensor edge to lampada change 3 clk edges; A/B pulse to output change 1 clk edge.
REQ-024 SHALL treat A/B held high for multiple cycles as one event per cycle high; no edge detection inside this block.
REQ-025 SHALL recover an illegal state encoding to AUTO_OFF on next edge.

Reset
REQ-026 SHALL, while rst=1 at a clk edge, set state AUTO_OFF, counter 0, synchronizer flops 0; lampada=0, modo_manual=0 from that edge.
REQ-027 SHALL have rst mid-operation (any state, any counter value) override all inputs; first transition possible on first edge after rst falls.

Structure
REQ-028 SHALL put estado_t enum (4 states, 2-bit) and default HOLD_T/CNT_W constants in shared package controle_pkg.
REQ-029 SHALL instantiate sub-module sincronizador (parameterized 2-flop, synchronous active-high reset) twice.
REQ-030 SHALL have no latches, a single clock domain, and registered state/counter only.

Verification (HOLD_T=8 for bench)
REQ-031 SHALL cover: rst, escuro=1, presence pulse 1 cycle -> lampada=1 after 3 edges, then 0 exactly 8 cycles after pres_s falls.
REQ-032 SHALL cover: escuro=0, presence=1 for 20 cycles -> lampada stays 0; then escuro=1 -> lampada=1 after 3 edges.
REQ-033 SHALL cover: AUTO_ON, presence re-pulsed at counter=6 -> counter clears, lampada stays 1 for 8 more cycles.
REQ-034 SHALL cover: A pulse in AUTO_ON -> MAN_ON (modo_manual=1, lampada=1); B -> lampada=0; B -> lampada=1; presence changes ignored.
REQ-035 SHALL cover: A and B together in MAN_ON -> AUTO_OFF, lampada=0, modo_manual=0; no toggle applied.
REQ-036 SHALL cover: rst asserted in MAN_ON and in AUTO_ON at counter=5 -> next edge lampada=0, modo_manual=0, counter=0.
